// File: rtl/nn_pkg.sv
// nn_pkg: shared defaults, FSM state type and constants for layer_sequencer.
package nn_pkg;

    localparam int NUM_ROWS_DEFAULT = 10;
    localparam int MAX_WAIT_DEFAULT = 1023;
    localparam int ROW_IDX_W        = 4;
    localparam int DATA_W           = 32;

    localparam logic [DATA_W-1:0] SAT_VALUE = 32'h7FFF_FFFF;
    localparam logic [DATA_W-1:0] MAX_INIT  = 32'h8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        STORE,
        NEXT,
        FINISH,
        DRAIN,
        ERROR
    } seq_state_t;

endpackage

// File: rtl/flex_counter.sv
// flex_counter: clearable up-counter that wraps to zero once it reaches rollover_val-1.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

    // Flag marks the final count so the owner can stop before the wrap.
    assign rollover_flag = (count_out == (rollover_val - CNT_ONE));

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            count_out <= rollover_flag ? '0 : count_out + CNT_ONE;
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: steps a row multiplier through one image, stores each row and tracks the arg-max.
// Build option: define OVF_SATURATE_EN to replace overflowed rows with the positive saturation value.
module layer_sequencer
    import nn_pkg::*;
#(
    parameter int NUM_ROWS = NUM_ROWS_DEFAULT,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              abort,
    output logic [3:0]        row_select,
    output logic              begin_mult,
    input  logic              done_row,
    input  logic [DATA_W-1:0] row_result,
    input  logic              overflow,
    input  logic              w_result_ena,
    output logic              result_wr_en,
    output logic [3:0]        result_wr_addr,
    output logic [DATA_W-1:0] result_wr_data,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [3:0]        class_out,
    output logic [DATA_W-1:0] max_value,
    output logic              ovf_sticky
);

    localparam int WD_W = $clog2(MAX_WAIT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_WAIT - 1);
    localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);

    seq_state_t            state;
    logic [WD_W-1:0]       wd_cnt;
    logic [ROW_IDX_W-1:0]  row_idx;
    logic                  last_row;
    logic                  cnt_clear;
    logic                  cnt_en;
    logic [DATA_W-1:0]     row_eff;

`ifdef OVF_SATURATE_EN
    assign row_eff = overflow ? SAT_VALUE : row_result;
`else
    assign row_eff = row_result;
`endif

    // Counter moves on the same edge the FSM leaves IDLE/NEXT, so controls are decoded from state.
    always_comb begin
        cnt_clear = (state == IDLE) && start;
        cnt_en    = (state == NEXT) && !abort && !last_row;
    end

    flex_counter #(
        .NUM_CNT_BITS (ROW_IDX_W)
    ) u_row_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (cnt_clear),
        .count_enable  (cnt_en),
        .rollover_val  (ROW_IDX_W'(NUM_ROWS)),
        .count_out     (row_idx),
        .rollover_flag (last_row)
    );

    assign row_select = row_idx;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state          <= IDLE;
            wd_cnt         <= '0;
            begin_mult     <= 1'b0;
            result_wr_en   <= 1'b0;
            result_wr_addr <= '0;
            result_wr_data <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            class_out      <= '0;
            max_value      <= MAX_INIT;
            ovf_sticky     <= 1'b0;
        end else begin
            begin_mult   <= 1'b0;
            result_wr_en <= 1'b0;
            done         <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LAUNCH;
                        begin_mult <= 1'b1;
                        busy       <= 1'b1;
                        error      <= 1'b0;
                        ovf_sticky <= 1'b0;
                        max_value  <= MAX_INIT;
                        class_out  <= '0;
                        wd_cnt     <= '0;
                    end
                end

                LAUNCH: begin
                    wd_cnt <= '0;
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (abort) begin
                        // A row finishing in the abort cycle needs no drain.
                        if (done_row) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else if (done_row && w_result_ena) begin
                        state          <= STORE;
                        result_wr_en   <= 1'b1;
                        result_wr_addr <= row_idx;
                        result_wr_data <= row_eff;
                        if (overflow) begin
                            ovf_sticky <= 1'b1;
                        end
                    end else if (wd_cnt == WD_LIMIT) begin
                        state <= ERROR;
                        error <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_ONE;
                    end
                end

                STORE: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= NEXT;
                        if ($signed(result_wr_data) > $signed(max_value)) begin
                            max_value <= result_wr_data;
                            class_out <= result_wr_addr;
                        end
                    end
                end

                NEXT: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (last_row) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        state      <= LAUNCH;
                        begin_mult <= 1'b1;
                    end
                end

                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                DRAIN: begin
                    if (done_row) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end

                ERROR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: scoreboarded bench with a behavioural multiplier and image-level reference model.
`timescale 1ns/1ps
module tb_layer_sequencer;

    localparam int N  = 10;
    localparam int MW = 1023;

    logic        clk = 1'b0;
    logic        n_rst, start, abort;
    logic [3:0]  row_select;
    logic        begin_mult;
    logic        done_row, overflow, w_result_ena;
    logic [31:0] row_result;
    logic        result_wr_en;
    logic [3:0]  result_wr_addr;
    logic [31:0] result_wr_data;
    logic        busy, done, error;
    logic [3:0]  class_out;
    logic [31:0] max_value;
    logic        ovf_sticky;

    layer_sequencer #(.NUM_ROWS(N), .MAX_WAIT(MW)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .start          (start),
        .abort          (abort),
        .row_select     (row_select),
        .begin_mult     (begin_mult),
        .done_row       (done_row),
        .row_result     (row_result),
        .overflow       (overflow),
        .w_result_ena   (w_result_ena),
        .result_wr_en   (result_wr_en),
        .result_wr_addr (result_wr_addr),
        .result_wr_data (result_wr_data),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .class_out      (class_out),
        .max_value      (max_value),
        .ovf_sticky     (ovf_sticky)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct { int addr; logic [31:0] data; } wr_t;
    typedef struct { int cls; logic [31:0] maxv; logic ovf; int lat; int start_cyc; } dn_t;
    wr_t wq[$];
    dn_t dq[$];

    logic [31:0] m_rows[16];
    logic        m_ovf[16];
    int          m_lat[16];
    int          m_hold = 15;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name, input string req);
        checks++;
        errors++;
        $display("FAIL %s: got nothing required %s", name, req);
    endtask

    // Value the sequencer should write for row i.
    function automatic logic [31:0] eff(input int i);
`ifdef OVF_SATURATE_EN
        if (m_ovf[i]) return 32'h7FFF_FFFF;
`endif
        return m_rows[i];
    endfunction

    task automatic expect_writes(input int upto);
        for (int i = 0; i < upto; i++) wq.push_back('{addr: i, data: eff(i)});
    endtask

    task automatic expect_done(input int sc);
        dn_t d;
        int best = 0;
        d.ovf = 1'b0;
        d.lat = 2;
        for (int i = 0; i < N; i++) begin
            if ($signed(eff(i)) > $signed(eff(best))) best = i;
            d.ovf = d.ovf | m_ovf[i];
            d.lat = d.lat + m_lat[i] + 3;
        end
        d.cls = best;
        d.maxv = eff(best);
        d.start_cyc = sc;
        dq.push_back(d);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_error"}, 32'(error), 32'd0);
        check({tag, "_ovf"}, 32'(ovf_sticky), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_begin"}, 32'(begin_mult), 32'd0);
        check({tag, "_wren"}, 32'(result_wr_en), 32'd0);
        check({tag, "_class"}, 32'(class_out), 32'd0);
        check({tag, "_max"}, max_value, 32'h8000_0000);
        check({tag, "_rowsel"}, 32'(row_select), 32'd0);
    endtask

    task automatic kick(output int sc);
        @(posedge clk); #1;
        start = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("start_busy", 32'(busy), 32'd1);
        check("start_err_clr", 32'(error), 32'd0);
        check("start_ovf_clr", 32'(ovf_sticky), 32'd0);
        check("start_class_clr", 32'(class_out), 32'd0);
        check("start_max_init", max_value, 32'h8000_0000);
    endtask

    task automatic wait_idle(input int budget, input bit noisy, output int ic);
        int n = 0;
        ic = -1;
        while (1) begin
            @(negedge clk);
            if (!busy) begin
                start = 1'b0;
                ic = cyc;
                return;
            end
            if (n == budget) begin
                start = 1'b0;
                note_fail("timeout_idle", "busy=0");
                return;
            end
            if (noisy) start = ($urandom_range(0, 3) == 0);
            n++;
        end
    endtask

    task automatic wait_launch(input int row, output int lc);
        lc = -1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (begin_mult && int'(row_select) == row) begin
                lc = cyc;
                return;
            end
        end
        note_fail("timeout_launch", "begin_mult");
    endtask

    task automatic run_full(input bit noisy);
        int sc, ic;
        kick(sc);
        expect_writes(N);
        expect_done(sc);
        wait_idle(600, noisy, ic);
        check("done_consumed", 32'(dq.size()), 32'd0);
        check("idle_err", 32'(error), 32'd0);
    endtask

    task automatic randomize_rows();
        for (int i = 0; i < N; i++) begin
            case ($urandom_range(0, 2))
                0: m_rows[i] = $urandom;
                1: m_rows[i] = 32'($urandom_range(0, 6)) - 32'd3;
                default: m_rows[i] = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            endcase
            m_ovf[i] = ($urandom_range(0, 5) == 0);
            m_lat[i] = $urandom_range(1, 5);
        end
    endtask

    // Behavioural multiplier: answers each launch after m_lat[row] cycles unless that row is held.
    initial begin
        int idx;
        done_row = 1'b0;
        w_result_ena = 1'b0;
        overflow = 1'b0;
        row_result = '0;
        forever begin
            @(posedge clk); #1;
            if (n_rst && begin_mult && int'(row_select) != m_hold) begin
                idx = int'(row_select);
                repeat (m_lat[idx]) @(posedge clk);
                #1;
                done_row = 1'b1;
                w_result_ena = 1'b1;
                row_result = m_rows[idx];
                overflow = m_ovf[idx];
                @(posedge clk); #1;
                done_row = 1'b0;
                w_result_ena = 1'b0;
                overflow = 1'b0;
                row_result = $urandom;
            end
        end
    end

    initial begin
        wr_t w;
        dn_t d;
        forever begin
            @(negedge clk);
            if (n_rst === 1'b1) begin
                if (result_wr_en === 1'b1) begin
                    if (wq.size() == 0) begin
                        note_fail("unexpected_write", "no write");
                    end else begin
                        w = wq.pop_front();
                        check("wr_addr", 32'(result_wr_addr), 32'(w.addr));
                        check("wr_data", result_wr_data, w.data);
                    end
                end
                if (done === 1'b1) begin
                    if (dq.size() == 0) begin
                        note_fail("unexpected_done", "no done");
                    end else begin
                        d = dq.pop_front();
                        check("done_class", 32'(class_out), 32'(d.cls));
                        check("done_max", max_value, d.maxv);
                        check("done_ovf", 32'(ovf_sticky), 32'(d.ovf));
                        check("done_latency", 32'(cyc - d.start_cyc + 1), 32'(d.lat));
                        check("done_wr_left", 32'(wq.size()), 32'd0);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int t035[10] = '{5, -3, 90, 7, 12, -8, 33, 0, 64, 1};
        int sc, ic, lc, seen;

        n_rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_rows[i] = '0;
            m_ovf[i] = 1'b0;
            m_lat[i] = 1;
        end
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check_reset_vals("post_rst");

        // Directed image: argmax at row 2, fixed latency.
        for (int i = 0; i < N; i++) begin
            m_rows[i] = 32'(t035[i]);
            m_lat[i] = 2;
        end
        run_full(1'b0);
        check("hold_class", 32'(class_out), 32'd2);
        check("hold_max", max_value, 32'd90);

        // Tie: first occurrence wins.
        for (int i = 0; i < N; i++) begin
            m_rows[i] = '0;
            m_lat[i] = 1;
        end
        m_rows[3] = 32'd40;
        m_rows[6] = 32'd40;
        run_full(1'b0);
        check("tie_class", 32'(class_out), 32'd3);

        // Overflow on row 1.
        for (int i = 0; i < N; i++) m_rows[i] = 32'(i * 3);
        m_rows[1] = 32'h0000_1234;
        m_ovf[1] = 1'b1;
        run_full(1'b0);
        check("ovf_sticky_held", 32'(ovf_sticky), 32'd1);
        m_ovf[1] = 1'b0;

        for (int k = 0; k < 8; k++) begin
            randomize_rows();
            run_full(1'b1);
        end

        // Watchdog: row 4 never answers.
        randomize_rows();
        m_hold = 4;
        kick(sc);
        expect_writes(4);
        wait_launch(4, lc);
        wait_idle(MW + 200, 1'b0, ic);
        check("wd_idle_cycle", 32'(ic), 32'(lc + MW + 2));
        check("wd_error", 32'(error), 32'd1);
        check("wd_busy", 32'(busy), 32'd0);
        m_hold = 15;
        repeat (3) @(negedge clk);
        check("wd_error_sticky", 32'(error), 32'd1);

        // Abort in WAIT of row 2 drains until the row returns.
        randomize_rows();
        m_lat[2] = 6;
        kick(sc);
        expect_writes(2);
        wait_launch(2, lc);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("drain_busy", 32'(busy), 32'd1);
        wait_idle(100, 1'b0, ic);
        check("drain_exit_cycle", 32'(ic), 32'(lc + 7));
        repeat (3) @(negedge clk);

        // Abort coinciding with done_row of row 3.
        randomize_rows();
        m_lat[3] = 3;
        kick(sc);
        expect_writes(3);
        seen = 0;
        for (int n = 0; n < 400 && seen == 0; n++) begin
            @(negedge clk);
            if (done_row && row_select == 4'd3) seen = 1;
        end
        if (seen == 0) note_fail("timeout_row3_done", "done_row");
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_done_idle", 32'(busy), 32'd0);
        repeat (5) @(negedge clk);

        // Asynchronous reset in WAIT of row 7.
        randomize_rows();
        m_lat[7] = 5;
        kick(sc);
        expect_writes(7);
        wait_launch(7, lc);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_reset_vals("async_rst");
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        repeat (10) @(negedge clk);

        randomize_rows();
        run_full(1'b1);

        check("wq_empty", 32'(wq.size()), 32'd0);
        check("dq_empty", 32'(dq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
